// File: rtl/screen_mode_ctrl_pkg.sv
// Shared definitions for the screen mode controller: FSM state encoding and the
// one-hot screen codes understood by the VGA renderer.
package screen_pkg;

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_ABOUT     = 3'd1,
        S_MANUAL    = 3'd2,
        S_DISPENSER = 3'd3,
        S_TIMESET   = 3'd4,
        S_DISPENSE  = 3'd5
    } state_t;

    localparam logic [3:0] SCR_MENU      = 4'b0000;
    localparam logic [3:0] SCR_ABOUT     = 4'b0001;
    localparam logic [3:0] SCR_MANUAL    = 4'b0010;
    localparam logic [3:0] SCR_DISPENSER = 4'b0100;
    localparam logic [3:0] SCR_TIMESET   = 4'b1000;

    localparam int NUM_BTN = 5;
    localparam int BACK_IDX = 4;

    // DISPENSE has no screen of its own; callers map it through ret_state first.
    function automatic logic [3:0] scr_code(input state_t s);
        logic [3:0] code;
        code = SCR_MENU;
        case (s)
            S_ABOUT:     code = SCR_ABOUT;
            S_MANUAL:    code = SCR_MANUAL;
            S_DISPENSER: code = SCR_DISPENSER;
            S_TIMESET:   code = SCR_TIMESET;
            default:     code = SCR_MENU;
        endcase
        return code;
    endfunction

    function automatic logic is_screen(input state_t s);
        return (s == S_ABOUT) || (s == S_MANUAL) || (s == S_DISPENSER) || (s == S_TIMESET);
    endfunction

endpackage

// File: rtl/screen_mode_ctrl_if.sv
// Bus between the front panel / dispenser side and the screen mode controller.
interface screen_mode_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       btn;
    logic             btn_back;
    logic             dispense_start;
    logic [CNT_W-1:0] pill_count;
    logic             frame_start;
    logic [3:0]       inp;
    logic             dispensing;
    logic             lowmeds;
    logic             screen_changed;

    modport master (
        output btn, btn_back, dispense_start, pill_count, frame_start,
        input  inp, dispensing, lowmeds, screen_changed
    );

    modport slave (
        input  btn, btn_back, dispense_start, pill_count, frame_start,
        output inp, dispensing, lowmeds, screen_changed
    );
endinterface

// File: rtl/screen_mode_ctrl_btn_debounce.sv
// One raw push-button: 2-FF synchronizer, stability counter, and a 1-cycle press
// pulse on the accepted 0->1 edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync_p1;
                press <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/screen_mode_ctrl.sv
// Screen select FSM feeding the VGA renderer; outputs only change on frame_start.
// Optional build macro SCREEN_TIMEOUT_EN adds an inactivity return to the menu.
module screen_mode_ctrl
    import screen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int DISP_HOLD_CYCLES = 150000000,
    parameter int LOW_THRESH       = 3,
    parameter int CNT_W            = 8
`ifdef SCREEN_TIMEOUT_EN
    ,
    parameter int IDLE_CYCLES      = 1500000000
`endif
) (
    input  logic             clock,
    input  logic             reset,
    screen_mode_ctrl_if.slave bus
);
    localparam int HOLD_W = $clog2(DISP_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DISP_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_T     = CNT_W'(LOW_THRESH);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] pulse;
    logic [NUM_BTN-1:0] press;
    logic               any_press;

    assign raw       = {bus.btn_back, bus.btn};
    assign press     = pulse & level;
    assign any_press = |press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock(clock),
            .reset(reset),
            .raw  (raw[i]),
            .level(level[i]),
            .press(pulse[i])
        );
    end

    state_t              state;
    state_t              state_nx;
    state_t              ret_state;
    state_t              ret_nx;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nx;
    logic                idle_expired;

`ifdef SCREEN_TIMEOUT_EN
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nx;

    assign idle_expired = (idle_cnt == IDLE_LAST);

    always_comb begin
        idle_nx = '0;
        if (bus.dispense_start || any_press || (state_nx != state)) begin
            idle_nx = '0;
        end else if (is_screen(state)) begin
            idle_nx = idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_nx;
        end
    end
`else
    assign idle_expired = 1'b0;
`endif

    // FSM: dispense_start outranks every button press in the same cycle.
    always_comb begin
        state_nx = state;
        ret_nx   = ret_state;
        hold_nx  = hold_cnt;
        if (bus.dispense_start) begin
            state_nx = S_DISPENSE;
            hold_nx  = HOLD_LOAD;
            if (state != S_DISPENSE) begin
                ret_nx = state;
            end
        end else begin
            case (state)
                S_MENU: begin
                    if (press[3]) begin
                        state_nx = S_TIMESET;
                    end else if (press[2]) begin
                        state_nx = S_DISPENSER;
                    end else if (press[1]) begin
                        state_nx = S_MANUAL;
                    end else if (press[0]) begin
                        state_nx = S_ABOUT;
                    end
                end
                S_ABOUT, S_MANUAL, S_DISPENSER, S_TIMESET: begin
                    if (press[BACK_IDX] || idle_expired) begin
                        state_nx = S_MENU;
                    end
                end
                S_DISPENSE: begin
                    if (hold_cnt == '0) begin
                        state_nx = ret_state;
                    end else begin
                        hold_nx = hold_cnt - 1'b1;
                    end
                end
                default: state_nx = S_MENU;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_MENU;
            ret_state <= S_MENU;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            hold_cnt  <= hold_nx;
        end
    end

    logic [3:0] pend_inp;
    logic       pend_disp;
    state_t     view;

    assign view      = (state == S_DISPENSE) ? ret_state : state;
    assign pend_inp  = scr_code(view);
    assign pend_disp = (state == S_DISPENSE);

    // Frame commit: the renderer only ever sees values latched at frame_start.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.inp            <= SCR_MENU;
            bus.dispensing     <= 1'b0;
            bus.lowmeds        <= 1'b0;
            bus.screen_changed <= 1'b0;
        end else if (bus.frame_start) begin
            bus.inp            <= pend_inp;
            bus.dispensing     <= pend_disp;
            bus.lowmeds        <= (bus.pill_count <= LOW_T);
            bus.screen_changed <= (pend_inp != bus.inp) || (pend_disp != bus.dispensing);
        end else begin
            bus.screen_changed <= 1'b0;
        end
    end
endmodule

// File: tb/tb_screen_mode_ctrl.sv
// Scoreboard bench for screen_mode_ctrl: directed scenarios plus random button,
// dispense and pill-count activity checked against a behavioural model.
module tb_screen_mode_ctrl;
    localparam int DEB  = 4;
    localparam int HOLD = 50;
    localparam int IDLE = 100;
    localparam int LOWT = 3;
    localparam int FRAME = 20;

    logic clk;
    logic rst;

    screen_mode_ctrl_if #(.CNT_W(8)) sif ();

    screen_mode_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .DISP_HOLD_CYCLES(HOLD),
        .LOW_THRESH      (LOWT),
        .CNT_W           (8)
`ifdef SCREEN_TIMEOUT_EN
        ,
        .IDLE_CYCLES     (IDLE)
`endif
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] inp;
        logic       disp;
        logic       low;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Model: current screen index (0 menu, 1..4), remaining dispense clocks, idle clocks.
    int        m_scr;
    int        m_left;
    int        m_idle;
    bit [3:0]  m_inp;
    bit        m_disp;
    bit        m_low;
    bit        m_chg;
    bit [4:0]  m_level;
    bit [4:0]  m_press;
    bit [15:0] hist[5];

    task automatic model_reset();
        m_scr = 0; m_left = 0; m_idle = 0;
        m_inp = 4'b0; m_disp = 0; m_low = 0; m_chg = 0;
        m_level = '0; m_press = '0;
        for (int b = 0; b < 5; b++) hist[b] = '0;
    endtask

    task automatic model_step();
        exp_t     e;
        bit [3:0] code;
        bit       dnow;
        bit       anyp;
        bit       flip;
        int       prev_scr;
        bit       prev_d;
        bit [4:0] rawv;
        if (rst) begin
            model_reset();
            exp_q.push_back('0);
            return;
        end
        m_chg = 0;
        if (sif.frame_start) begin
            code   = (m_scr == 0) ? 4'b0000 : 4'(1 << (m_scr - 1));
            dnow   = (m_left > 0);
            m_chg  = (code != m_inp) || (dnow != m_disp);
            m_inp  = code;
            m_disp = dnow;
            m_low  = (int'(sif.pill_count) <= LOWT);
        end
        prev_scr = m_scr;
        prev_d   = (m_left > 0);
        anyp     = |m_press;
        if (sif.dispense_start) m_left = HOLD;
        else if (m_left > 0) m_left--;
        else if (m_scr == 0) begin
            if (m_press[3]) m_scr = 4;
            else if (m_press[2]) m_scr = 3;
            else if (m_press[1]) m_scr = 2;
            else if (m_press[0]) m_scr = 1;
        end
        else if (m_press[4]) m_scr = 0;
`ifdef SCREEN_TIMEOUT_EN
        else if (m_idle == IDLE - 1) m_scr = 0;
        if (sif.dispense_start || anyp || (m_scr != prev_scr) || ((m_left > 0) != prev_d)) m_idle = 0;
        else if (m_scr != 0 && m_left == 0) m_idle++;
        else m_idle = 0;
`endif
        // A button is accepted once DEB synchronized samples (2 clocks old) all disagree with it.
        rawv = {sif.btn_back, sif.btn};
        m_press = '0;
        for (int b = 0; b < 5; b++) begin
            hist[b] = {hist[b][14:0], rawv[b]};
            flip = 1;
            for (int k = 2; k <= DEB + 1; k++) if (hist[b][k] == m_level[b]) flip = 0;
            if (flip) begin
                m_level[b] = ~m_level[b];
                m_press[b] = m_level[b];
            end
        end
        e.inp  = m_inp;
        e.disp = m_disp;
        e.low  = m_low;
        e.chg  = m_chg;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        sif.frame_start = ((cyc % FRAME) == FRAME - 1);
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic hold_btn(input int idx, input int n);
        if (idx == 4) sif.btn_back = 1'b1;
        else sif.btn[idx] = 1'b1;
        run(n);
        if (idx == 4) sif.btn_back = 1'b0;
        else sif.btn[idx] = 1'b0;
    endtask

    task automatic pulse_dispense();
        sif.dispense_start = 1'b1;
        tick();
        sif.dispense_start = 1'b0;
    endtask

    // Monitor: every clock the DUT presents a committed view; compare it to the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({sif.inp, sif.dispensing, sif.lowmeds, sif.screen_changed} !== {e.inp, e.disp, e.low, e.chg}) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d got inp=%b disp=%b low=%b chg=%b want inp=%b disp=%b low=%b chg=%b",
                             cyc, sif.inp, sif.dispensing, sif.lowmeds, sif.screen_changed,
                             e.inp, e.disp, e.low, e.chg);
                end
                n_tests++;
                if (!$onehot0(sif.inp)) begin
                    n_fail++;
                    $display("FAIL onehot cyc=%0d got inp=%b want one-hot or zero", cyc, sif.inp);
                end
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b1;
        sif.btn = 4'b0;
        sif.btn_back = 1'b0;
        sif.dispense_start = 1'b0;
        sif.pill_count = 8'd10;
        sif.frame_start = 1'b0;
        run(3);
        rst = 1'b0;
        // Idle frames, then a dispenser-screen visit and return.
        run(3 * FRAME);
        hold_btn(2, 10);
        run(40);
        hold_btn(4, 10);
        run(40);
        // Short glitch, then simultaneous presses resolved by priority.
        hold_btn(0, 2);
        run(30);
        sif.btn = 4'b1010;
        run(10);
        sif.btn = 4'b0000;
        run(40);
        // Dispense in TIMESET with a reload 30 clocks in.
        pulse_dispense();
        run(29);
        pulse_dispense();
        run(100);
        // Low-medication threshold crossing mid-frame.
        sif.pill_count = 8'd4;
        run(2 * FRAME + 7);
        sif.pill_count = 8'd3;
        run(40);
        // Reset while dispensing.
        pulse_dispense();
        run(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(20);
        // ABOUT left untouched long enough to trip the optional timeout.
        hold_btn(0, 10);
        run(200);
        hold_btn(4, 10);
        run(30);
        // Random activity.
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 15) == 0) sif.btn[b] = ~sif.btn[b];
            if ($urandom_range(0, 15) == 0) sif.btn_back = ~sif.btn_back;
            sif.dispense_start = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) sif.pill_count = 8'($urandom_range(0, 7));
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 1'b0;
        sif.dispense_start = 1'b0;
        run(5);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
